// File: rtl/dclk_pkg.sv
// Shared definitions for the clock's decimal/binary conversion paths:
// converter state encoding, BCD digit limit and reverse double-dabble constants.
package dclk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } dec2bin_state_t;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
  localparam logic [3:0] NIB_CORR_TH   = 4'd8;
  localparam logic [3:0] NIB_CORR_ADJ  = 4'd3;

  // 10**n, used to check at elaboration that the binary width holds every BCD value
  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_nib_corr.sv
// One BCD nibble correction step of reverse double-dabble:
// after a right shift, a nibble of 8 or more is reduced by 3 (modulo 16).
module bcd_nib_corr
  import dclk_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= NIB_CORR_TH) ? din - NIB_CORR_ADJ : din;

endmodule

// File: rtl/dec2bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one shift per cycle).
// Optional result clamping to MAX_VAL is enabled by defining DEC2BIN_SAT_EN.
module dec2bin_seq
  import dclk_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int BIN_W   = 7,
  parameter int MAX_VAL = 99
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd,
  output logic                busy,
  output logic                done,
  output logic [BIN_W-1:0]    binary,
  output logic                err,
  output logic                ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  if (pow10(DIGITS) - 1 >= (longint'(1) << BIN_W)) begin : g_bad_width
    $error("dec2bin_seq: BIN_W=%0d cannot hold %0d BCD digits", BIN_W, DIGITS);
  end
  if (longint'(MAX_VAL) >= (longint'(1) << BIN_W)) begin : g_bad_max
    $error("dec2bin_seq: MAX_VAL=%0d does not fit in BIN_W=%0d", MAX_VAL, BIN_W);
  end

  dec2bin_state_t state, state_nxt;
  logic [SR_W-1:0]  sr, sr_shr, sr_nxt;
  logic [BCD_W-1:0] corr_bcd;
  logic [CNT_W-1:0] cnt;
  logic             bcd_bad;
  logic             last_shift;
  logic [BIN_W-1:0] sat_res;
  logic             sat_flag;

  assign sr_shr = sr >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    bcd_nib_corr u_corr (
      .din  (sr_shr[BIN_W+4*g +: 4]),
      .dout (corr_bcd[4*g +: 4])
    );
  end

  assign sr_nxt     = {corr_bcd, sr_shr[BIN_W-1:0]};
  assign last_shift = (cnt == CNT_W'(BIN_W - 1));

  always_comb begin
    bcd_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] > BCD_DIGIT_MAX) bcd_bad = 1'b1;
    end
  end

`ifdef DEC2BIN_SAT_EN
  always_comb begin
    sat_res  = sr_nxt[BIN_W-1:0];
    sat_flag = 1'b0;
    if (sr_nxt[BIN_W-1:0] > BIN_W'(MAX_VAL)) begin
      sat_res  = BIN_W'(MAX_VAL);
      sat_flag = 1'b1;
    end
  end
`else
  assign sat_res  = sr_nxt[BIN_W-1:0];
  assign sat_flag = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = bcd_bad ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (last_shift) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

  // Result registers change only on the edge that enters DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr     <= '0;
      cnt    <= '0;
      binary <= '0;
      err    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !bcd_bad) begin
            sr  <= {bcd, {BIN_W{1'b0}}};
            cnt <= '0;
          end else if (start) begin
            binary <= '0;
            err    <= 1'b1;
            ovf    <= 1'b0;
          end
        end
        ST_SHIFT: begin
          sr  <= sr_nxt;
          cnt <= cnt + 1'b1;
          if (last_shift) begin
            binary <= sat_res;
            err    <= 1'b0;
            ovf    <= sat_flag;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
